// File: rtl/smol_boi_pkg.sv
// Shared constants for the smol_boi SPI multiplier: parameter defaults,
// frame-edge indices derived from the operand width, and the frame phase type.
package smol_boi_pkg;

    localparam int WIDTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // Edge 1 of every frame is a dummy edge whose MOSI bit is discarded.
    localparam int DUMMY_EDGE = 1;

    // Frame phases as seen by the edge currently being processed.
    typedef enum logic [2:0] {
        PH_DUMMY,
        PH_OP_A,
        PH_OP_B,
        PH_TURN,
        PH_OUT,
        PH_DONE
    } phase_e;

    // First edge that shifts an A bit.
    function automatic int a_first_edge(input int w);
        return 2;
    endfunction

    // First edge that shifts a B bit.
    function automatic int b_first_edge(input int w);
        return w + 2;
    endfunction

    // Edge carrying the last B bit; the product is loaded on this edge too.
    function automatic int load_edge(input int w);
        return 2 * w + 1;
    endfunction

    // Edge that drives the product MSB onto MISO.
    function automatic int first_out_edge(input int w);
        return 2 * w + 4;
    endfunction

    // Edge that drives the product LSB onto MISO.
    function automatic int last_out_edge(input int w);
        return 4 * w + 3;
    endfunction

endpackage

// File: rtl/smol_boi_spi_sync_edge.sv
// Synchronizes SCLK, CS and MOSI into the CLK domain through equal-depth
// flop chains and produces a one-cycle pulse on each SCLK falling edge.
module smol_boi_spi_sync_edge
    import smol_boi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic cs_s_o,
    output logic mosi_s_o,
    output logic sclk_fall_o
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev_q;

    // Identical chain depth keeps MOSI aligned with the SCLK edge it belongs to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_q      <= '0;
            cs_q        <= '0;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            cs_q        <= {cs_q[SYNC_STAGES-2:0], cs_i};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    // Falling edge: synchronized SCLK is low now and was high last cycle.
    always_comb begin
        sclk_fall_o = sclk_prev_q & ~sclk_q[SYNC_STAGES-1];
        cs_s_o      = cs_q[SYNC_STAGES-1];
        mosi_s_o    = mosi_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/smol_boi.sv
// SPI-slave multiplier: shifts in operands A and B MSB first, multiplies them,
// and shifts the 2*WIDTH-bit product back out on MISO MSB first.
module smol_boi
    import smol_boi_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCLK,
    input  logic CS,
    input  logic MOSI,
    output logic MISO
);

    // Counter must reach one past the last output edge, where it saturates.
    localparam int CNT_W = $clog2(last_out_edge(WIDTH) + 2);

    localparam logic [CNT_W-1:0] K_DUMMY   = CNT_W'(DUMMY_EDGE);
    localparam logic [CNT_W-1:0] K_B_LO    = CNT_W'(b_first_edge(WIDTH));
    localparam logic [CNT_W-1:0] K_LOAD    = CNT_W'(load_edge(WIDTH));
    localparam logic [CNT_W-1:0] K_OUT_LO  = CNT_W'(first_out_edge(WIDTH));
    localparam logic [CNT_W-1:0] K_OUT_HI  = CNT_W'(last_out_edge(WIDTH));
    localparam logic [CNT_W-1:0] K_SAT     = CNT_W'(last_out_edge(WIDTH) + 1);

    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_fall;

    logic [CNT_W-1:0]       k_q, k_d, k_inc;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [2*WIDTH-1:0]     p_q, p_d;
    logic                   miso_q, miso_d;
    phase_e                 phase;

    smol_boi_spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (CLK),
        .rst_i       (RST),
        .sclk_i      (SCLK),
        .cs_i        (CS),
        .mosi_i      (MOSI),
        .cs_s_o      (cs_s),
        .mosi_s_o    (mosi_s),
        .sclk_fall_o (sclk_fall)
    );

    // Number the incoming edge (saturating) and classify it into a frame phase.
    always_comb begin
        k_inc = (k_q == K_SAT) ? k_q : k_q + CNT_W'(1);
        phase = PH_DONE;
        if (k_inc == K_DUMMY)       phase = PH_DUMMY;
        else if (k_inc < K_B_LO)    phase = PH_OP_A;
        else if (k_inc <= K_LOAD)   phase = PH_OP_B;
        else if (k_inc < K_OUT_LO)  phase = PH_TURN;
        else if (k_inc <= K_OUT_HI) phase = PH_OUT;
    end

    // Frame actions: CS low aborts and clears; each falling edge advances one step.
    always_comb begin
        k_d    = k_q;
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        miso_d = miso_q;
        if (!cs_s) begin
            k_d    = '0;
            a_d    = '0;
            b_d    = '0;
            p_d    = '0;
            miso_d = 1'b0;
        end else if (sclk_fall) begin
            k_d    = k_inc;
            miso_d = 1'b0;
            case (phase)
                PH_OP_A: a_d = {a_q[WIDTH-2:0], mosi_s};
                PH_OP_B: begin
                    b_d = {b_q[WIDTH-2:0], mosi_s};
                    // Last B bit arrives on this edge, so multiply using b_d.
                    if (k_inc == K_LOAD) begin
                        p_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_d};
                    end
                end
                PH_OUT: begin
                    miso_d = p_q[2*WIDTH-1];
                    p_d    = {p_q[2*WIDTH-2:0], 1'b0};
                end
                default: miso_d = 1'b0;
            endcase
        end
    end

    // State registers; reset clears everything and forces MISO low at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            miso_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            miso_q <= miso_d;
        end
    end

    assign MISO = miso_q;

endmodule

// File: tb/tb_smol_boi.sv
// Bench for smol_boi: directed and random SPI frames compared edge by edge
// against an expected MISO stream built from the frame rules.
module tb_smol_boi;

  localparam int W     = 4;
  localparam int HALF  = 10;   // CLK cycles per SCLK half-period (400 ns SCLK)

  logic clk = 1'b0;
  logic rst;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];

  smol_boi #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .CLK  (clk),
    .RST  (rst),
    .SCLK (sclk),
    .CS   (cs),
    .MOSI (mosi),
    .MISO (miso)
  );

  // clock/reset block
  always #10 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver: one CS-framed transaction of n_edges SCLK periods. Expected
  // MISO after edge k: 0 before the output window, product bit (MSB first)
  // inside it, 0 after it.
  task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int n_edges, input bit keep_cs);
    logic [2*W-1:0] p;
    logic got;
    logic [0:0] exp;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    for (int k = 1; k <= n_edges; k++) begin
      if (k >= 2*W + 4 && k <= 4*W + 3) exp_q.push_back(p[4*W + 3 - k]);
      else exp_q.push_back(1'b0);
    end
    cs = 1'b1;
    wait_cycles(HALF);
    for (int k = 1; k <= n_edges; k++) begin
      sclk = 1'b1;
      if (k >= 2 && k <= W + 1) mosi = a[W + 1 - k];
      else if (k >= W + 2 && k <= 2*W + 1) mosi = b[2*W + 1 - k];
      else mosi = 1'($urandom_range(0, 1));
      wait_cycles(HALF);
      sclk = 1'b0;
      wait_cycles(HALF - 1);
      got = miso;
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp[0]) begin
        n_fail++;
        $display("FAIL miso_edge k=%0d a=%0d b=%0d: got %b expected %b", k, a, b, got, exp[0]);
      end
      wait_cycles(1);
    end
    if (!keep_cs) begin
      cs = 1'b0;
      wait_cycles(HALF);
      n_checks++;
      if (miso !== 1'b0) begin
        n_fail++;
        $display("FAIL miso_cs_low a=%0d b=%0d: got %b expected 0", a, b, miso);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cs = 1'b0; sclk = 1'b0; mosi = 1'b0;
    wait_cycles(5);
    n_checks++;
    if (miso !== 1'b0) begin
      n_fail++;
      $display("FAIL miso_reset: got %b expected 0", miso);
    end
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_cs_low_idle;
    for (int i = 0; i < 12; i++) begin
      sclk = 1'b1;
      mosi = 1'($urandom_range(0, 1));
      wait_cycles(HALF);
      sclk = 1'b0;
      wait_cycles(HALF);
      n_checks++;
      if (miso !== 1'b0) begin
        n_fail++;
        $display("FAIL miso_idle edge=%0d: got %b expected 0", i, miso);
      end
    end
  endtask

  task automatic test_directed;
    run_frame(4'd1, 4'd6, 19, 1'b0);
    run_frame(4'd15, 4'd15, 19, 1'b0);
    run_frame(4'd0, 4'd11, 19, 1'b0);
  endtask

  task automatic test_abort;
    run_frame(4'd10, 4'd7, 7, 1'b0);
    run_frame(4'd3, 4'd5, 19, 1'b0);
  endtask

  task automatic test_reset_mid;
    // 3*5 = 15: edge 16 drives product bit 3, which is 1.
    run_frame(4'd3, 4'd5, 16, 1'b1);
    rst = 1'b1;
    #1;
    n_checks++;
    if (miso !== 1'b0) begin
      n_fail++;
      $display("FAIL miso_async_rst: got %b expected 0", miso);
    end
    wait_cycles(3);
    rst = 1'b0;
    cs = 1'b0;
    wait_cycles(HALF);
    run_frame(4'd2, 4'd3, 19, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                19 + $urandom_range(0, 4), 1'b0);
      wait_cycles($urandom_range(0, 6));
    end
  endtask

  task automatic test_back_to_back;
    run_frame(4'd9, 4'd13, 19, 1'b0);
    run_frame(4'd12, 4'd4, 21, 1'b0);
  endtask

  initial begin
    test_reset();
    test_cs_low_idle();
    test_directed();
    test_abort();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
